// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = x - y - bin, LSB first,
// one borrow-propagate slice per clock with a valid/ready handshake.
module serial_subtractor #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  in_ready,
    input  logic [data_width-1:0] x,
    input  logic [data_width-1:0] y,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [data_width-1:0] diff,
    output logic                  bout,
    output logic                  zero,
    output logic                  ovf
);

    localparam int cw = (data_width < 2) ? 1 : $clog2(data_width + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [cw-1:0]         cnt;
    logic [data_width-1:0] xs, ys, diff_n;
    logic                  b, d, b_n, last;

    assign d    = xs[0] ^ ys[0] ^ b;
    assign b_n  = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
    assign last = (cnt == cw'(data_width - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start)   state_n = RUN;
            RUN:     if (last)    state_n = DONE;
            DONE:    if (out_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // New result bit enters at the MSB so diff is aligned after the last shift.
    always_comb begin
        diff_n                 = diff >> 1;
        diff_n[data_width-1]   = d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xs   <= '0;
            ys   <= '0;
            b    <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        xs  <= x;
                        ys  <= y;
                        b   <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    diff <= diff_n;
                    xs   <= xs >> 1;
                    ys   <= ys >> 1;
                    b    <= b_n;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        bout <= b_n;
                        ovf  <= b ^ b_n;
                        zero <= (diff_n == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit and 1-bit instances.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       start8 = 0, bin8 = 0, ack8 = 0;
    logic [7:0] x8 = 0, y8 = 0;
    logic       rdy8, ov8, bout8, zero8, ovf8;
    logic [7:0] diff8;

    logic       start1 = 0, bin1 = 0, ack1 = 0;
    logic [0:0] x1 = 0, y1 = 0;
    logic       rdy1, ov1, bout1, zero1, ovf1;
    logic [0:0] diff1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.data_width(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .in_ready(rdy8),
        .x(x8), .y(y8), .bin(bin8), .out_valid(ov8), .out_ack(ack8),
        .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
    );

    serial_subtractor #(.data_width(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .in_ready(rdy1),
        .x(x1), .y(y1), .bin(bin1), .out_valid(ov1), .out_ack(ack1),
        .diff(diff1), .bout(bout1), .zero(zero1), .ovf(ovf1)
    );

    // Accept one op on dut8 and wait for out_valid; lat = edges after accept.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic bi, output int lat);
        @(negedge clk);
        x8 = a; y8 = b; bin8 = bi; start8 = 1;
        @(negedge clk);
        start8 = 0;
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack8_op();
        ack8 = 1;
        @(negedge clk);
        ack8 = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #12;
        checks++;
        if (rdy8 !== 1 || ov8 !== 0 || diff8 !== 8'h00 || bout8 !== 0
            || zero8 !== 0 || ovf8 !== 0) begin
            errors++;
            $display("FAIL reset8 rdy=%b ov=%b diff=%h bout=%b zero=%b ovf=%b want 1 0 00 0 0 0",
                     rdy8, ov8, diff8, bout8, zero8, ovf8);
        end
        checks++;
        if (rdy1 !== 1 || ov1 !== 0 || diff1 !== 1'b0) begin
            errors++;
            $display("FAIL reset1 rdy=%b ov=%b diff=%b want 1 0 0", rdy1, ov1, diff1);
        end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        checks++;
        if (rdy8 !== 1 || ov8 !== 0) begin
            errors++;
            $display("FAIL post_reset rdy=%b ov=%b want 1 0", rdy8, ov8);
        end
    endtask

    task automatic test_basic();
        int lat;
        run8(8'h35, 8'h12, 0, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL latency got %0d want 8", lat);
        end
        checks++;
        if ({diff8, bout8, zero8, ovf8} !== {8'h23, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic diff=%h b=%b z=%b o=%b want 23 0 0 0",
                     diff8, bout8, zero8, ovf8);
        end
        ack8_op();
    endtask

    task automatic test_borrow_ovf();
        int lat;
        run8(8'h00, 8'h01, 0, lat);
        checks++;
        if (lat !== 8 || {diff8, bout8, ovf8} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL 00-01 lat=%0d diff=%h b=%b o=%b want 8 ff 1 0",
                     lat, diff8, bout8, ovf8);
        end
        ack8_op();
        run8(8'h80, 8'h01, 0, lat);
        checks++;
        if (lat !== 8 || {diff8, bout8, ovf8} !== {8'h7F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL 80-01 lat=%0d diff=%h b=%b o=%b want 8 7f 0 1",
                     lat, diff8, bout8, ovf8);
        end
        ack8_op();
        run8(8'h7F, 8'hFF, 0, lat);
        checks++;
        if (lat !== 8 || {diff8, bout8, ovf8} !== {8'h80, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL 7f-ff lat=%0d diff=%h b=%b o=%b want 8 80 1 1",
                     lat, diff8, bout8, ovf8);
        end
        ack8_op();
    endtask

    task automatic test_zero();
        int lat;
        run8(8'h5A, 8'h5A, 0, lat);
        checks++;
        if ({diff8, zero8, bout8} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero diff=%h z=%b b=%b want 00 1 0", diff8, zero8, bout8);
        end
        ack8_op();
        run8(8'h5A, 8'h5A, 1, lat);
        checks++;
        if ({diff8, zero8, bout8, ovf8} !== {8'hFF, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_bin diff=%h z=%b b=%b o=%b want ff 0 1 0",
                     diff8, zero8, bout8, ovf8);
        end
        ack8_op();
    endtask

    task automatic test_hold_and_ack();
        int lat;
        int bad;
        @(negedge clk);
        x8 = 8'hA0; y8 = 8'h30; bin8 = 0; start8 = 1;
        @(negedge clk);
        lat = 0;
        bad = 0;
        while (!ov8 && lat < 20) begin
            if (rdy8 !== 0) bad++;
            start8 = ~start8;
            x8 = x8 + 8'h11;
            y8 = y8 ^ 8'h5C;
            @(negedge clk);
            lat++;
        end
        start8 = 0;
        checks++;
        if (lat !== 8 || bad !== 0) begin
            errors++;
            $display("FAIL run_busy lat=%0d ready_hits=%0d want 8 0", lat, bad);
        end
        checks++;
        if ({diff8, bout8, zero8, ovf8} !== {8'h70, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL toggled diff=%h b=%b z=%b o=%b want 70 0 0 1",
                     diff8, bout8, zero8, ovf8);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            start8 = 1;
            @(negedge clk);
            if (ov8 !== 1 || rdy8 !== 0 || diff8 !== 8'h70 || ovf8 !== 1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold unstable_cycles=%0d want 0", bad);
        end
        start8 = 1; x8 = 8'h01; y8 = 8'h01;
        ack8 = 1;
        @(negedge clk);
        ack8 = 0;
        start8 = 0;
        checks++;
        if (rdy8 !== 1 || ov8 !== 0) begin
            errors++;
            $display("FAIL ack rdy=%b ov=%b want 1 0", rdy8, ov8);
        end
        @(negedge clk);
        checks++;
        if (rdy8 !== 1) begin
            errors++;
            $display("FAIL ack_start rdy=%b want 1", rdy8);
        end
    endtask

    task automatic test_abort();
        int lat;
        @(negedge clk);
        x8 = 8'hC3; y8 = 8'h21; bin8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (ov8 !== 0 || rdy8 !== 1 || diff8 !== 8'h00) begin
            errors++;
            $display("FAIL abort ov=%b rdy=%b diff=%h want 0 1 00", ov8, rdy8, diff8);
        end
        @(negedge clk);
        reset_n = 1;
        run8(8'h10, 8'h01, 0, lat);
        checks++;
        if (lat !== 8 || {diff8, bout8, ovf8} !== {8'h0F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_abort lat=%0d diff=%h b=%b o=%b want 8 0f 0 0",
                     lat, diff8, bout8, ovf8);
        end
        ack8_op();
    endtask

    task automatic test_width1();
        // {x, y, bin} -> {diff, bout}
        logic [1:0] tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01,
                                2'b10, 2'b00, 2'b00, 2'b11};
        logic [2:0] v;
        int lat;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            x1 = v[2]; y1 = v[1]; bin1 = v[0]; start1 = 1;
            @(negedge clk);
            start1 = 0;
            lat = 0;
            while (!ov1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 1 || {diff1, bout1} !== tbl[i]
                || ovf1 !== (v[0] ^ tbl[i][0])
                || zero1 !== ~tbl[i][1]) begin
                errors++;
                $display("FAIL w1 xyb=%b lat=%0d d=%b b=%b o=%b z=%b want 1 %b %b %b %b",
                         v, lat, diff1, bout1, ovf1, zero1, tbl[i][1],
                         tbl[i][0], v[0] ^ tbl[i][0], ~tbl[i][1]);
            end
            ack1 = 1;
            @(negedge clk);
            ack1 = 0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_zero();
        test_hold_and_ack();
        test_abort();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
